// File: rtl/membus_arbiter_pkg.sv
// Shared bus/RAM types for the memory bus arbiter: width defaults, master limit, arbiter FSM states.
package project_types;

    localparam int MEMBUS_MAX_MASTERS = 8;
    localparam int RAM_ADDR_W         = 32;
    localparam int RAM_DATA_W         = 32;

    typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
    typedef logic [RAM_DATA_W-1:0] ram_data_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

endpackage

// File: rtl/membus_arbiter_rr.sv
// Combinational round-robin picker: first requester found scanning last+1, last+2, ... mod N.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] grant
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        valid  = 1'b0;
        grant  = '0;
        w_cand = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IDX_W'((int'(last) + k) % N);
            if (!valid && req[w_cand]) begin
                valid = 1'b1;
                grant = w_cand;
            end
        end
    end

endmodule

// File: rtl/membus_arbiter.sv
// N-master to 1-slave memory bus arbiter, round-robin grant, variable-latency slave ack.
// Optional slave-wait abort enabled by defining MEMBUS_ARB_TIMEOUT_EN.
//
//   state    | meaning
//   ARB_IDLE | no transaction; picks the next eligible master
//   ARB_BUSY | request latched to slave, waiting for s_ack (or timeout)
module membus_arbiter
    import project_types::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_W         = $bits(ram_addr_t),
    parameter int DATA_W         = $bits(ram_data_t),
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTERS-1:0]          m_ce,
    input  logic [NUM_MASTERS-1:0]          m_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
    output logic [DATA_W-1:0]               m_rdata,
    output logic [NUM_MASTERS-1:0]          m_ack,
    output logic                            m_err,
    output logic                            s_ce,
    output logic                            s_we,
    output logic [ADDR_W-1:0]               s_addr,
    output logic [DATA_W-1:0]               s_wdata,
    input  logic [DATA_W-1:0]               s_rdata,
    input  logic                            s_ack,
    output logic [$clog2(NUM_MASTERS)-1:0]  grant_id,
    output logic                            busy
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > MEMBUS_MAX_MASTERS) begin : g_bad_masters
        $error("membus_arbiter: NUM_MASTERS must be within 2..%0d", MEMBUS_MAX_MASTERS);
    end
    if (TIMEOUT_CYCLES < 0) begin : g_bad_timeout
        $error("membus_arbiter: TIMEOUT_CYCLES must be non-negative");
    end

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic                   w_grant_go;
    logic                   w_done;
    logic                   w_abort;
    logic                   w_tmo;

    logic [NUM_MASTERS-1:0] w_elig;
    logic                   w_arb_valid;
    logic [IDX_W-1:0]       w_arb_idx;
    logic [ADDR_W-1:0]      w_addr_arr  [NUM_MASTERS];
    logic [DATA_W-1:0]      w_wdata_arr [NUM_MASTERS];

    logic [DATA_W-1:0]      r_rdata;
    logic [NUM_MASTERS-1:0] r_m_ack;
    logic                   r_err;
    logic                   r_s_ce;
    logic                   r_s_we;
    logic [ADDR_W-1:0]      r_s_addr;
    logic [DATA_W-1:0]      r_s_wdata;
    logic [IDX_W-1:0]       r_grant;
    logic [IDX_W-1:0]       r_last;

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi] = m_wdata[gi*DATA_W +: DATA_W];
    end

    // The master acked this cycle still has m_ce high; mask it so it is not re-granted.
    assign w_elig = m_ce & ~r_m_ack;

    rr_arbiter #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (w_elig),
        .last  (r_last),
        .valid (w_arb_valid),
        .grant (w_arb_idx)
    );

`ifdef MEMBUS_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tcnt;

    // Down-counter loaded on grant; terminal count means the wait limit is used up.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (w_grant_go) begin
            r_tcnt <= TMO_W'(TIMEOUT_CYCLES);
        end else if (r_state == ARB_BUSY && !s_ack && r_tcnt != '0) begin
            r_tcnt <= r_tcnt - 1'b1;
        end
    end

    assign w_tmo = (r_tcnt == '0);
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_go  = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_arb_valid) begin
                    w_grant_go  = 1'b1;
                    w_state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // A slave ack on the expiry cycle wins over the abort.
                if (s_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end else if (w_tmo) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata   <= '0;
            r_m_ack   <= '0;
            r_err     <= 1'b0;
            r_s_ce    <= 1'b0;
            r_s_we    <= 1'b0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_grant   <= '0;
            r_last    <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            r_m_ack <= '0;
            if (w_grant_go) begin
                r_s_ce    <= 1'b1;
                r_s_we    <= m_we[w_arb_idx];
                r_s_addr  <= w_addr_arr[w_arb_idx];
                r_s_wdata <= w_wdata_arr[w_arb_idx];
                r_grant   <= w_arb_idx;
            end
            if (w_done || w_abort) begin
                r_s_ce  <= 1'b0;
                r_m_ack <= NUM_MASTERS'(1) << r_grant;
                r_rdata <= w_done ? s_rdata : '0;
                r_err   <= w_abort;
                r_last  <= r_grant;
            end
        end
    end

    assign m_rdata  = r_rdata;
    assign m_ack    = r_m_ack;
    assign m_err    = r_err;
    assign s_ce     = r_s_ce;
    assign s_we     = r_s_we;
    assign s_addr   = r_s_addr;
    assign s_wdata  = r_s_wdata;
    assign grant_id = r_grant;
    assign busy     = (r_state == ARB_BUSY);

endmodule
